// File: rtl/spi_master_bridge_if.sv
// Request/response and SPI pin bundle for spi_master_bridge.
// master = requester and SPI-target side, slave = the bridge itself.
interface spi_master_bridge_if #(
   parameter int XLEN = 32
);
   logic            i_start;
   logic            i_write;
   logic [XLEN-1:0] i_addr;
   logic [XLEN-1:0] i_wr_data;
   logic [3:0]      i_size;
   logic            o_busy;
   logic            o_done;
   logic            o_err;
   logic [XLEN-1:0] o_rd_data;
   logic            o_sclk;
   logic            o_cs;
   logic            o_mosi;
   logic            i_miso;

   modport master (
      output i_start, i_write, i_addr, i_wr_data, i_size, i_miso,
      input  o_busy, o_done, o_err, o_rd_data, o_sclk, o_cs, o_mosi
   );

   modport slave (
      input  i_start, i_write, i_addr, i_wr_data, i_size, i_miso,
      output o_busy, o_done, o_err, o_rd_data, o_sclk, o_cs, o_mosi
   );
endinterface

// File: rtl/spi_master_bridge.sv
// Bus-request to SPI (mode 0) bridge: serialises one command/address/data frame per
// request and returns the read word shifted in from MISO.
module spi_master_bridge #(
   parameter int CLK_DIV    = 4,
   parameter int DUMMY_BITS = 8,
   parameter int XLEN       = 32
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   spi_master_bridge_if.slave bus_if
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SETUP    = 3'd1;
   localparam logic [2:0] S_SHIFT_HI = 3'd2;
   localparam logic [2:0] S_SHIFT_LO = 3'd3;
   localparam logic [2:0] S_HOLD     = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam int         FRAME_W  = 8 + 2 * XLEN;
   localparam logic [6:0] LAST_WR  = 7'(FRAME_W - 1);
   localparam logic [6:0] LAST_RD  = 7'(FRAME_W + DUMMY_BITS - 1);
   localparam logic [6:0] RX_FIRST = 7'(FRAME_W + DUMMY_BITS - XLEN);
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [3:0] OP_WR    = 4'h1;
   localparam logic [3:0] OP_RD    = 4'h2;

   logic [2:0]         state_q, state_d;
   logic [7:0]         div_q, div_d;
   logic [6:0]         bit_q, bit_d;
   logic [FRAME_W-1:0] tx_q, tx_d;
   logic [XLEN-1:0]    rx_q, rx_d;
   logic [XLEN-1:0]    rd_data_q, rd_data_d;
   logic               write_q, write_d;
   logic               cs_q, cs_d;
   logic               sclk_q, sclk_d;
   logic               mosi_q, mosi_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               div_end_s;
   logic [6:0]         bit_last_s;
   logic [6:0]         cap_idx_s;
   logic               cap_en_s;
   logic [XLEN-1:0]    rx_shift_s;
   logic [FRAME_W-1:0] frame_s;

   assign div_end_s  = (div_q == DIV_LAST);
   assign bit_last_s = write_q ? LAST_WR : LAST_RD;
   // Index of the bit whose rising SCLK is produced by the current move into SHIFT_HI.
   assign cap_idx_s  = (state_q == S_SETUP) ? 7'd0 : (bit_q + 7'd1);
   assign cap_en_s   = !write_q && (cap_idx_s >= RX_FIRST);
   assign rx_shift_s = cap_en_s ? {rx_q[XLEN-2:0], bus_if.i_miso} : rx_q;
   assign frame_s    = {(bus_if.i_write ? OP_WR : OP_RD), bus_if.i_size, bus_if.i_addr,
                        (bus_if.i_write ? bus_if.i_wr_data : {XLEN{1'b0}})};

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rd_data_d = rd_data_q;
      write_d   = write_q;
      cs_d      = cs_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;

      case (state_q)
         S_IDLE: begin
            if (bus_if.i_start) begin
               write_d = bus_if.i_write;
               busy_d  = 1'b1;
               div_d   = 8'd0;
               bit_d   = 7'd0;
               if (bus_if.i_size == 4'b0000) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_SETUP;
                  cs_d    = 1'b0;
                  mosi_d  = frame_s[FRAME_W-1];
                  tx_d    = {frame_s[FRAME_W-2:0], 1'b0};
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_SETUP: begin
            if (div_end_s) begin
               state_d = S_SHIFT_HI;
               div_d   = 8'd0;
               sclk_d  = 1'b1;
               rx_d    = rx_shift_s;
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         S_SHIFT_HI: begin
            // tx_q drains to zero, so dummy/read bits and the post-frame level are all 0.
            if (div_end_s) begin
               state_d = S_SHIFT_LO;
               div_d   = 8'd0;
               sclk_d  = 1'b0;
               mosi_d  = tx_q[FRAME_W-1];
               tx_d    = {tx_q[FRAME_W-2:0], 1'b0};
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         S_SHIFT_LO: begin
            if (div_end_s) begin
               div_d = 8'd0;
               if (bit_q == bit_last_s) begin
                  state_d = S_HOLD;
               end else begin
                  state_d = S_SHIFT_HI;
                  bit_d   = bit_q + 7'd1;
                  sclk_d  = 1'b1;
                  rx_d    = rx_shift_s;
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         S_HOLD: begin
            if (div_end_s) begin
               state_d = S_DONE;
               div_d   = 8'd0;
               cs_d    = 1'b1;
               done_d  = 1'b1;
               if (!write_q) begin
                  rd_data_d = rx_q;
               end else begin
                  rd_data_d = rd_data_q;
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            bit_d   = 7'd0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            div_d   = 8'd0;
            bit_d   = 7'd0;
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
         end
      endcase
   end

   // State and output registers; pins return to idle levels as soon as reset asserts.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         div_q     <= 8'd0;
         bit_q     <= 7'd0;
         tx_q      <= {FRAME_W{1'b0}};
         rx_q      <= {XLEN{1'b0}};
         rd_data_q <= {XLEN{1'b0}};
         write_q   <= 1'b0;
         cs_q      <= 1'b1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rd_data_q <= rd_data_d;
         write_q   <= write_d;
         cs_q      <= cs_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign bus_if.o_busy    = busy_q;
   assign bus_if.o_done    = done_q;
   assign bus_if.o_err     = err_q;
   assign bus_if.o_rd_data = rd_data_q;
   assign bus_if.o_sclk    = sclk_q;
   assign bus_if.o_cs      = cs_q;
   assign bus_if.o_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_bridge.sv
// Bench for spi_master_bridge: SPI target + word SRAM model, done-time scoreboard.
module tb_spi_master_bridge;

   localparam int CLK_DIV    = 4;
   localparam int DUMMY_BITS = 8;
   localparam int XLEN       = 32;
   localparam int N_WR       = 72;
   localparam int N_RD       = 80;
   localparam int LAT_WR     = 585;
   localparam int LAT_RD     = 649;

   typedef struct {
      int          exp_cyc;
      logic        err;
      logic [31:0] rd;
   } sb_item_t;

   sb_item_t sb_q[$];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   spi_master_bridge_if #(.XLEN(XLEN)) bus_if ();

   spi_master_bridge #(
      .CLK_DIV   (CLK_DIV),
      .DUMMY_BITS(DUMMY_BITS),
      .XLEN      (XLEN)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus_if (bus_if.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // SPI target with a word-addressed SRAM behind it, byte enables from the command.
   logic [31:0]  mem [logic [31:0]];
   logic [127:0] mosi_sh    = '0;
   logic [127:0] last_frame = '0;
   logic [7:0]   s_cmd      = 8'h00;
   logic [7:0]   last_cmd   = 8'h00;
   logic [31:0]  s_addr     = 32'h0;
   logic [31:0]  s_rd       = 32'h0;
   logic         prev_cs    = 1'b1;
   logic         prev_sclk  = 1'b0;
   int           rises      = 0;
   int           last_rises = 0;
   int           frames     = 0;

   always @(negedge clk) begin : spi_target
      logic [31:0] w;
      if (prev_cs === 1'b1 && bus_if.o_cs === 1'b0) begin
         rises         = 0;
         mosi_sh       = '0;
         s_cmd         = 8'h00;
         bus_if.i_miso = 1'b0;
         frames++;
      end
      if (bus_if.o_cs === 1'b0 && prev_sclk === 1'b0 && bus_if.o_sclk === 1'b1) begin
         mosi_sh = {mosi_sh[126:0], bus_if.o_mosi};
         rises++;
         if (rises == 40) begin
            s_cmd  = mosi_sh[39:32];
            s_addr = mosi_sh[31:0];
            s_rd   = mem.exists(s_addr) ? mem[s_addr] : 32'h0;
         end
      end
      if (bus_if.o_cs === 1'b0 && prev_sclk === 1'b1 && bus_if.o_sclk === 1'b0) begin
         if (s_cmd[7:4] == 4'h2 && rises >= N_RD - 32 && rises < N_RD)
            bus_if.i_miso = s_rd[N_RD - 1 - rises];
         else
            bus_if.i_miso = 1'b0;
      end
      if (prev_cs === 1'b0 && bus_if.o_cs === 1'b1) begin
         last_rises = rises;
         last_frame = mosi_sh;
         last_cmd   = s_cmd;
         if (rises == N_WR && s_cmd[7:4] == 4'h1) begin
            w = mem.exists(s_addr) ? mem[s_addr] : 32'h0;
            for (int b = 0; b < 4; b++)
               if (s_cmd[b]) w[8*b +: 8] = mosi_sh[8*b +: 8];
            mem[s_addr] = w;
         end
      end
      prev_cs   = bus_if.o_cs;
      prev_sclk = bus_if.o_sclk;
   end

   // Scoreboard: every o_done must match the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      sb_item_t it;
      if (bus_if.o_done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_val("spurious_done", bus_if.o_done, 32'd0);
         end else begin
            it = sb_q.pop_front();
            check_val("done_cycle", cyc, it.exp_cyc);
            check_val("err", bus_if.o_err, it.err);
            check_val("rd_data", bus_if.o_rd_data, it.rd);
            check_val("busy_in_done", bus_if.o_busy, 32'd1);
            check_val("cs_in_done", bus_if.o_cs, 32'd1);
         end
      end else if (bus_if.o_err === 1'b1) begin
         check_val("err_without_done", bus_if.o_err, 32'd0);
      end
   end

   task automatic start_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] size, input logic [31:0] exp_rd, input int lat);
      sb_item_t it;
      @(negedge clk);
      bus_if.i_start   = 1'b1;
      bus_if.i_write   = wr;
      bus_if.i_addr    = addr;
      bus_if.i_wr_data = data;
      bus_if.i_size    = size;
      it.exp_cyc = cyc + lat;
      it.err     = (size == 4'h0);
      it.rd      = exp_rd;
      sb_q.push_back(it);
      @(negedge clk);
      bus_if.i_start = 1'b0;
      check_val("busy_after_start", bus_if.o_busy, 32'd1);
      check_val("cs_after_start", bus_if.o_cs, {31'd0, (size == 4'h0)});
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb_q.size() != 0 || bus_if.o_busy !== 1'b0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_val("txn_complete", sb_q.size(), 32'd0);
      check_val("idle_busy", bus_if.o_busy, 32'd0);
   endtask

   initial begin
      int f0;
      int n;
      bus_if.i_start   = 1'b0;
      bus_if.i_write   = 1'b0;
      bus_if.i_addr    = 32'h0;
      bus_if.i_wr_data = 32'h0;
      bus_if.i_size    = 4'h0;
      mem[32'h4000_0300] = 32'hCAFE_F00D;

      repeat (3) @(negedge clk);
      check_val("rst_cs", bus_if.o_cs, 32'd1);
      check_val("rst_sclk", bus_if.o_sclk, 32'd0);
      check_val("rst_mosi", bus_if.o_mosi, 32'd0);
      check_val("rst_busy", bus_if.o_busy, 32'd0);
      check_val("rst_done", bus_if.o_done, 32'd0);
      check_val("rst_err", bus_if.o_err, 32'd0);
      check_val("rst_rd_data", bus_if.o_rd_data, 32'd0);
      rst_n = 1'b1;

      // Write frame, bit-exact MOSI stream
      start_txn(1'b1, 32'h4000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, LAT_WR);
      wait_idle();
      check_val("wr_rises", last_rises, N_WR);
      check_val("wr_cmd", {24'd0, last_frame[71:64]}, 32'h0000_001F);
      check_val("wr_addr", last_frame[63:32], 32'h4000_0100);
      check_val("wr_data", last_frame[31:0], 32'hDEAD_BEEF);

      // Read frame with dummy turnaround
      start_txn(1'b0, 32'h4000_0300, 32'h0, 4'hF, 32'hCAFE_F00D, LAT_RD);
      wait_idle();
      check_val("rd_rises", last_rises, N_RD);
      check_val("rd_cmd", {24'd0, last_cmd}, 32'h0000_002F);
      check_val("rd_addr", last_frame[71:40], 32'h4000_0300);
      check_val("rd_mosi_zero", {31'd0, |last_frame[39:0]}, 32'd0);

      // Empty byte mask is rejected without touching the SPI pins
      f0 = frames;
      start_txn(1'b1, 32'h4000_0100, 32'h1111_2222, 4'h0, 32'hCAFE_F00D, 1);
      wait_idle();
      start_txn(1'b0, 32'h4000_0300, 32'h0, 4'h0, 32'hCAFE_F00D, 1);
      wait_idle();
      check_val("size0_no_frame", frames, f0);

      // i_start held through the whole frame and its DONE cycle
      f0 = frames;
      @(negedge clk);
      bus_if.i_start   = 1'b1;
      bus_if.i_write   = 1'b1;
      bus_if.i_addr    = 32'h4000_0104;
      bus_if.i_wr_data = 32'h0BAD_F00D;
      bus_if.i_size    = 4'hF;
      sb_q.push_back('{exp_cyc: cyc + LAT_WR, err: 1'b0, rd: 32'hCAFE_F00D});
      n = 0;
      while (bus_if.o_done !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus_if.i_start = 1'b0;
      repeat (20) @(negedge clk);
      check_val("held_start_frames", frames, f0 + 1);
      check_val("held_start_idle", bus_if.o_busy, 32'd0);
      check_val("held_start_queue", sb_q.size(), 32'd0);

      // Loop-back through the SRAM, full word then low half only
      start_txn(1'b1, 32'h4000_0200, 32'h1234_5678, 4'hF, 32'hCAFE_F00D, LAT_WR);
      wait_idle();
      start_txn(1'b0, 32'h4000_0200, 32'h0, 4'hF, 32'h1234_5678, LAT_RD);
      wait_idle();
      start_txn(1'b1, 32'h4000_0200, 32'hAABB_CCDD, 4'h3, 32'h1234_5678, LAT_WR);
      wait_idle();
      start_txn(1'b0, 32'h4000_0200, 32'h0, 4'hF, 32'h1234_CCDD, LAT_RD);
      wait_idle();

      // Reset in the middle of a read frame
      start_txn(1'b0, 32'h4000_0300, 32'h0, 4'hF, 32'hCAFE_F00D, LAT_RD);
      n = 0;
      while (rises < 40 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_val("reach_bit40", (rises >= 40), 32'd1);
      #1;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check_val("abort_cs", bus_if.o_cs, 32'd1);
      check_val("abort_sclk", bus_if.o_sclk, 32'd0);
      check_val("abort_mosi", bus_if.o_mosi, 32'd0);
      check_val("abort_busy", bus_if.o_busy, 32'd0);
      check_val("abort_rd_data", bus_if.o_rd_data, 32'd0);
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_val("abort_no_done_q", sb_q.size(), 32'd0);
      start_txn(1'b0, 32'h4000_0300, 32'h0, 4'hF, 32'hCAFE_F00D, LAT_RD);
      wait_idle();
      check_val("post_rst_rises", last_rises, N_RD);

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
